// File: rtl/sbox_all_if.sv
// sbox_all_if: SubBytes stream bus; master drives Indata/in_valid, slave returns data/out_valid
interface sbox_all_if;
  logic [127:0] Indata;
  logic         in_valid;
  logic [127:0] data;
  logic         out_valid;
  modport master (output Indata, in_valid, input data, out_valid);
  modport slave (input Indata, in_valid, output data, out_valid);
endinterface

// File: rtl/sbox_all.sv
// sbox_all: AES forward S-box on all 16 bytes, one registered stage; ports sc (clock), rst (sync high), bus.slave (Indata/in_valid in, data/out_valid out)
module sbox_all (
  input logic       sc,
  input logic       rst,
  sbox_all_if.slave bus
);
  localparam logic [7:0] SBOX_T [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[b];
  endfunction
  logic [127:0] s;
  for (genvar k = 0; k < 16; k++) begin : g_lane
    assign s[8*k+:8] = sbox(bus.Indata[8*k+:8]);
  end
  always_ff @(posedge sc) begin
    if (rst) begin
      bus.data      <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      bus.data      <= bus.in_valid ? s : bus.data;
    end
  end
endmodule

// File: tb/tb_sbox_all.sv
// tb_sbox_all: randomized self-checking bench for sbox_all against an arithmetic GF(2^8) S-box model
module tb_sbox_all;
  logic sc = 1'b0;
  logic rst = 1'b0;
  sbox_all_if bus ();
  sbox_all dut (.sc(sc), .rst(rst), .bus(bus));
  always #5 sc = ~sc;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]   ref_tab [256];
  logic [127:0] exp_data;
  logic         exp_valid;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S(x) = affine(x^-1), inverse taken as x^254 in GF(2^8) with 0 mapping to 0
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv, y;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    y = 8'h63;
    for (int r = 0; r < 5; r++) y = y ^ rotl(inv, r);
    return y;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k+:8] = ref_tab[x[8*k+:8]];
    return r;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [127:0] d);
    rst = r;
    bus.in_valid = v;
    bus.Indata = d;
    @(posedge sc);
    if (r) begin
      exp_data = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) exp_data = ref_state(d);
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, {4{$urandom}});
      vectors++;
      if (bus.data !== 128'h0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold%0d: data=%h valid=%b, required 0/0", i, bus.data, bus.out_valid);
      end
    end
    cyc(1'b0, 1'b0, {4{$urandom}});
    vectors++;
    if (bus.data !== 128'h0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: data=%h valid=%b, required 0/0", bus.data, bus.out_valid);
    end
  endtask

  task automatic test_fips_vector;
    cyc(1'b0, 1'b1, 128'h3243f6a8885a308d313198a2e0370734);
    vectors++;
    if (bus.data !== 128'h231a42c2c4be045dc7c7463ae19ac518 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fips_vector: data=%h valid=%b, required 231a42c2c4be045dc7c7463ae19ac518/1", bus.data, bus.out_valid);
    end
    cyc(1'b0, 1'b0, {4{$urandom}});
    vectors++;
    if (bus.data !== 128'h231a42c2c4be045dc7c7463ae19ac518 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_hold: data=%h valid=%b, required 231a42c2c4be045dc7c7463ae19ac518/0", bus.data, bus.out_valid);
    end
  endtask

  task automatic test_anchors;
    cyc(1'b0, 1'b1, 128'h0);
    vectors++;
    if (bus.data !== {16{8'h63}} || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL all_zero: data=%h valid=%b, required %h/1", bus.data, bus.out_valid, {16{8'h63}});
    end
    cyc(1'b0, 1'b1, {16{8'hff}});
    vectors++;
    if (bus.data !== {16{8'h16}} || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL all_ff: data=%h valid=%b, required %h/1", bus.data, bus.out_valid, {16{8'h16}});
    end
    cyc(1'b0, 1'b1, {80'h0, 48'h00_01_53_ff_10_7f});
    vectors++;
    if (bus.data !== {{10{8'h63}}, 48'h63_7c_ed_16_ca_d2}) begin
      miscompares++;
      $display("FAIL anchors: data=%h, required %h", bus.data, {{10{8'h63}}, 48'h63_7c_ed_16_ca_d2});
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    vectors++;
    if (bus.data !== 128'h637c777bf26b6fc53001672bfed7ab76 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: data=%h valid=%b, required 637c777bf26b6fc53001672bfed7ab76/1", bus.data, bus.out_valid);
    end
    cyc(1'b0, 1'b1, 128'h101112131415161718191a1b1c1d1e1f);
    vectors++;
    if (bus.data !== 128'hca82c97dfa5947f0add4a2af9ca472c0 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: data=%h valid=%b, required ca82c97dfa5947f0add4a2af9ca472c0/1", bus.data, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] d;
    d = {4{$urandom}};
    cyc(1'b0, 1'b1, d);
    cyc(1'b1, 1'b1, {4{$urandom}});
    vectors++;
    if (bus.data !== 128'h0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: data=%h valid=%b, required 0/0", bus.data, bus.out_valid);
    end
    d = {4{$urandom}};
    cyc(1'b0, 1'b1, d);
    vectors++;
    if (bus.data !== ref_state(d) || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_resume: data=%h valid=%b, required %h/1", bus.data, bus.out_valid, ref_state(d));
    end
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, {16{8'(i)}});
      vectors++;
      if (bus.data !== {16{ref_tab[i]}} || bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL exhaustive_%02h: data=%h valid=%b, required %h/1", i, bus.data, bus.out_valid, {16{ref_tab[i]}});
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom});
      vectors++;
      if (bus.data !== exp_data || bus.out_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL random%0d: data=%h valid=%b, required %h/%b", i, bus.data, bus.out_valid, exp_data, exp_valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));
    bus.in_valid = 1'b0;
    bus.Indata = '0;
    exp_data = '0;
    exp_valid = 1'b0;
    test_reset;
    test_fips_vector;
    test_anchors;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
